// File: rtl/prune_ctrl_pkg.sv
// Shared types and defaults for the head-pruning accumulator controller.
//   state_e      : controller FSM states (3-bit encoding)
//   *_D          : default build parameters
//   clog2_min1() : counter/index width helper that never returns 0
package prune_ctrl_pkg;

  localparam int unsigned NUM_HEADS_D      = 12;
  localparam int unsigned TILES_PER_HEAD_D = 8;
  localparam int unsigned SETTLE_CYC_D     = 2;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Width for a counter/index covering 0..v-1; a 1-entry range still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd1) ? 32'd1 : 32'($clog2(v));
  endfunction

endpackage

// File: rtl/prune_mask_bank.sv
// Per-head prune mask register with synchronous clear and indexed single-bit write.
// Optional macro PRUNE_HEAD_STATS_EN adds a running count of set mask bits.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_clr            clear mask (and count) this edge
//   i_wr_en          write i_wr_bit into mask[i_wr_idx] this edge
//   i_wr_idx         head index to write
//   i_wr_bit         prune decision to store
//   o_mask           registered mask, bit h = head h pruned
//   o_pruned_cnt     (PRUNE_HEAD_STATS_EN only) number of set bits
module prune_mask_bank
  import prune_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_HEADS = NUM_HEADS_D,
  localparam int unsigned HW        = clog2_min1(NUM_HEADS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [HW-1:0]        i_wr_idx,
  input  logic                 i_wr_bit,
  output logic [NUM_HEADS-1:0] o_mask
`ifdef PRUNE_HEAD_STATS_EN
  ,
  output logic [HW:0]          o_pruned_cnt
`endif
);

  logic [NUM_HEADS-1:0] r_mask;

  // Mask storage; each head bit is written exactly once per layer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : mask_reg
    if (!i_rst_n) begin
      r_mask <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else if (i_wr_en) begin
      for (int unsigned i = 0; i < NUM_HEADS; i++) begin
        if (i_wr_idx == HW'(i)) r_mask[i] <= i_wr_bit;
      end
    end
  end

  assign o_mask = r_mask;

`ifdef PRUNE_HEAD_STATS_EN
  logic [HW:0] r_pruned_cnt;

  // Counts pruned heads incrementally rather than popcounting the mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : cnt_reg
    if (!i_rst_n) begin
      r_pruned_cnt <= '0;
    end else if (i_clr) begin
      r_pruned_cnt <= '0;
    end else if (i_wr_en && i_wr_bit) begin
      r_pruned_cnt <= r_pruned_cnt + (HW+1)'(1);
    end
  end

  assign o_pruned_cnt = r_pruned_cnt;
`endif

endmodule

// File: rtl/prune_head_ctrl.sv
// Sequences the absolute-sum head-pruning accumulator one head at a time:
// clear, accumulate TILES_PER_HEAD tiles, settle, compare, capture decision.
// Optional macro PRUNE_HEAD_STATS_EN adds o_pruned_cnt.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_start         layer start pulse, honoured only when idle
//   o_busy          high whenever not idle
//   o_done          one-cycle pulse after the last head is captured
//   i_tile_valid    tile presented by the sequencer
//   o_tile_ready    tile accepted (combinational, ACCUM only)
//   o_acc_clear     one-cycle accumulator clear
//   o_acc_enable    accumulator adds the tile this edge (combinational)
//   o_cmp_flag      one-cycle compare strobe
//   i_prune_in      threshold decision, valid the cycle after o_cmp_flag
//   o_head_idx      head being processed
//   o_prune_mask    per-head prune mask
//   o_mask_valid    mask complete and stable
//   o_pruned_cnt    (PRUNE_HEAD_STATS_EN only) count of pruned heads
module prune_head_ctrl
  import prune_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_HEADS      = NUM_HEADS_D,
  parameter  int unsigned TILES_PER_HEAD = TILES_PER_HEAD_D,
  parameter  int unsigned SETTLE_CYC     = SETTLE_CYC_D,
  localparam int unsigned HW             = clog2_min1(NUM_HEADS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_tile_valid,
  output logic                 o_tile_ready,
  output logic                 o_acc_clear,
  output logic                 o_acc_enable,
  output logic                 o_cmp_flag,
  input  logic                 i_prune_in,
  output logic [HW-1:0]        o_head_idx,
  output logic [NUM_HEADS-1:0] o_prune_mask,
  output logic                 o_mask_valid
`ifdef PRUNE_HEAD_STATS_EN
  ,
  output logic [HW:0]          o_pruned_cnt
`endif
);

  localparam int unsigned TW = clog2_min1(TILES_PER_HEAD);
  localparam int unsigned SW = clog2_min1(SETTLE_CYC);

  localparam logic [TW-1:0] TILE_LAST   = TW'(TILES_PER_HEAD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [HW-1:0] HEAD_LAST   = HW'(NUM_HEADS - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [TW-1:0] r_tile_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [HW-1:0] r_head_idx;
  logic          r_mask_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_acc_clear;
  logic          r_cmp_flag;

  logic w_tile_last;
  logic w_settle_last;
  logic w_head_last;
  logic w_start_ok;
  logic w_tile_ready;
  logic w_acc_enable;
  logic w_busy_d;
  logic w_done_d;
  logic w_acc_clear_d;
  logic w_cmp_flag_d;

  assign w_tile_last   = (r_tile_cnt == TILE_LAST);
  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_head_last   = (r_head_idx == HEAD_LAST);
  assign w_start_ok    = (r_state == ST_IDLE) && i_start;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; in ACCUM tile_ready is 1 so a transfer is just i_tile_valid.
  always_comb begin : next_comb
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR:   w_state_nxt = ST_ACCUM;
      ST_ACCUM:   if (i_tile_valid && w_tile_last) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (w_settle_last) w_state_nxt = ST_COMPARE;
      ST_COMPARE: w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = w_head_last ? ST_DONE : ST_CLEAR;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: handshake from current state, strobes decoded from next state so the
  // registered copies line up with the state they describe.
  always_comb begin : out_comb
    w_tile_ready  = 1'b0;
    w_acc_enable  = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    w_acc_clear_d = 1'b0;
    w_cmp_flag_d  = 1'b0;
    w_tile_ready  = (r_state == ST_ACCUM);
    w_acc_enable  = w_tile_ready && i_tile_valid;
    w_busy_d      = (w_state_nxt != ST_IDLE);
    w_done_d      = (w_state_nxt == ST_DONE);
    w_acc_clear_d = (w_state_nxt == ST_CLEAR);
    w_cmp_flag_d  = (w_state_nxt == ST_COMPARE);
  end

  // Registered strobes and status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : out_reg
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_clear <= 1'b0;
      r_cmp_flag  <= 1'b0;
    end else begin
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_acc_clear <= w_acc_clear_d;
      r_cmp_flag  <= w_cmp_flag_d;
    end
  end

  // Tile, settle and head counters plus mask-valid flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : ctr_reg
    if (!i_rst_n) begin
      r_tile_cnt   <= '0;
      r_settle_cnt <= '0;
      r_head_idx   <= '0;
      r_mask_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_head_idx   <= '0;
            r_mask_valid <= 1'b0;
          end
        end
        ST_CLEAR: r_tile_cnt <= '0;
        ST_ACCUM: begin
          if (w_acc_enable) begin
            r_tile_cnt <= r_tile_cnt + TW'(1);
            if (w_tile_last) r_settle_cnt <= '0;
          end
        end
        ST_SETTLE:  r_settle_cnt <= r_settle_cnt + SW'(1);
        ST_CAPTURE: if (!w_head_last) r_head_idx <= r_head_idx + HW'(1);
        ST_DONE:    r_mask_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  prune_mask_bank #(
    .NUM_HEADS (NUM_HEADS)
  ) u_mask_bank (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (w_start_ok),
    .i_wr_en      (r_state == ST_CAPTURE),
    .i_wr_idx     (r_head_idx),
    .i_wr_bit     (i_prune_in),
    .o_mask       (o_prune_mask)
`ifdef PRUNE_HEAD_STATS_EN
    ,
    .o_pruned_cnt (o_pruned_cnt)
`endif
  );

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_tile_ready = w_tile_ready;
  assign o_acc_clear  = r_acc_clear;
  assign o_acc_enable = w_acc_enable;
  assign o_cmp_flag   = r_cmp_flag;
  assign o_head_idx   = r_head_idx;
  assign o_mask_valid = r_mask_valid;

endmodule

// File: tb/tb_prune_head_ctrl.sv
// Self-checking bench for prune_head_ctrl. Randomized tile_valid and prune
// decisions; expectations come from the per-head cycle budget and the mask plan.
module tb_prune_head_ctrl;

`ifdef PRUNE_HEAD_STATS_EN
  localparam int unsigned NH = 12;
`else
  localparam int unsigned NH = 4;
`endif
  localparam int unsigned TPH      = 8;
  localparam int unsigned SC       = 2;
  localparam int unsigned HW       = $clog2(NH);
  // clear + tiles + settle + compare + capture
  localparam int          HEAD_CYC = 1 + TPH + SC + 1 + 1;
  localparam int          BUDGET   = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          tile_valid;
  logic          prune_in;
  logic          o_busy, o_done, o_tile_ready, o_acc_clear, o_acc_enable, o_cmp_flag;
  logic [HW-1:0] o_head_idx;
  logic [NH-1:0] o_prune_mask;
  logic          o_mask_valid;
`ifdef PRUNE_HEAD_STATS_EN
  logic [HW:0]   o_pruned_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int n_clear; int n_enable; int n_cmp; int n_done; int cyc_done;
    int bad_enable; int bad_head; int bad_settle; int bad_busy; int bad_mv;
    int bad_ready; int bad_idx; int bad_period;
    logic c0_mv; logic [NH-1:0] c0_mask;
    logic c1_clear; logic c1_mv; logic c1_busy; logic [NH-1:0] c1_mask; logic [HW-1:0] c1_head;
    logic [NH-1:0] mask_done; int cnt_done; int cnt_c1;
    bit timeout; bit reset_hit;
  } layer_obs_t;

  layer_obs_t obs;

  prune_head_ctrl #(
    .NUM_HEADS      (NH),
    .TILES_PER_HEAD (TPH),
    .SETTLE_CYC     (SC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_tile_valid (tile_valid),
    .o_tile_ready (o_tile_ready),
    .o_acc_clear  (o_acc_clear),
    .o_acc_enable (o_acc_enable),
    .o_cmp_flag   (o_cmp_flag),
    .i_prune_in   (prune_in),
    .o_head_idx   (o_head_idx),
    .o_prune_mask (o_prune_mask),
    .o_mask_valid (o_mask_valid)
`ifdef PRUNE_HEAD_STATS_EN
    ,
    .o_pruned_cnt (o_pruned_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Runs one layer from a start pulse; records observations for the calling test.
  // mode 0: tile_valid high, 1: toggling, 2: random. reset_head >= 0 asserts reset
  // in the first SETTLE cycle of that head and returns with reset held low.
  task automatic run_layer(input int mode, input logic [NH-1:0] plan,
                           input bit spurious, input int reset_head);
    int  last_xfer  = -100;
    int  en_since   = 0;
    int  last_clear = -1;
    bit  prev_cmp   = 1'b0;
    bit  spur_done  = 1'b0;
    bit  finished   = 1'b0;
    obs = '{default: 0};
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      if (spurious && !spur_done && o_tile_ready && o_head_idx == HW'(1)) begin
        start     = 1'b1;
        spur_done = 1'b1;
      end
      case (mode)
        0:       tile_valid = 1'b1;
        1:       tile_valid = ((cyc % 2) == 0);
        default: tile_valid = 1'($urandom_range(0, 1));
      endcase
      prune_in = prev_cmp ? plan[o_head_idx] : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) begin
        obs.c0_mv   = o_mask_valid;
        obs.c0_mask = o_prune_mask;
      end
      if (cyc == 1) begin
        obs.c1_clear = o_acc_clear;
        obs.c1_mv    = o_mask_valid;
        obs.c1_busy  = o_busy;
        obs.c1_mask  = o_prune_mask;
        obs.c1_head  = o_head_idx;
`ifdef PRUNE_HEAD_STATS_EN
        obs.cnt_c1   = int'(o_pruned_cnt);
`endif
      end
      if (o_acc_enable) begin
        obs.n_enable++;
        en_since++;
        last_xfer = cyc;
        if (!tile_valid || !o_tile_ready) obs.bad_enable++;
      end
      if (o_tile_ready && tile_valid && !o_acc_enable) obs.bad_enable++;
      if (o_tile_ready && (o_acc_clear || o_cmp_flag || o_done || !o_busy)) obs.bad_ready++;
      if (o_acc_clear) begin
        obs.n_clear++;
        if (mode == 0 && last_clear >= 0 && cyc - last_clear != HEAD_CYC) obs.bad_period++;
        last_clear = cyc;
        en_since   = 0;
      end
      if (o_cmp_flag) begin
        obs.n_cmp++;
        if (en_since != int'(TPH)) obs.bad_head++;
        if (cyc - last_xfer != int'(SC) + 1) obs.bad_settle++;
      end
      if (int'(o_head_idx) > int'(NH) - 1) obs.bad_idx++;
      if (cyc >= 1 && !o_done) begin
        if (!o_busy) obs.bad_busy++;
        if (o_mask_valid) obs.bad_mv++;
      end
      if (o_done) begin
        obs.n_done++;
        obs.cyc_done  = cyc;
        obs.mask_done = o_prune_mask;
`ifdef PRUNE_HEAD_STATS_EN
        obs.cnt_done  = int'(o_pruned_cnt);
`endif
        finished = 1'b1;
      end else if (reset_head >= 0 && int'(o_head_idx) == reset_head && o_busy &&
                   !o_tile_ready && en_since == int'(TPH) && cyc - last_xfer == 1) begin
        #1 rst_n = 1'b0;
        #1;
        obs.reset_hit = 1'b1;
        finished = 1'b1;
      end
      prev_cmp = o_cmp_flag;
    end
    start = 1'b0;
    if (!finished) obs.timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tile_valid = 1'b1; prune_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", o_busy); n_fail++; end
    n_cmp++; if (o_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", o_done); n_fail++; end
    n_cmp++; if (o_tile_ready !== 1'b0) begin $display("FAIL reset_tile_ready: got %b want 0", o_tile_ready); n_fail++; end
    n_cmp++; if (o_acc_enable !== 1'b0) begin $display("FAIL reset_acc_enable: got %b want 0", o_acc_enable); n_fail++; end
    n_cmp++; if (o_acc_clear !== 1'b0) begin $display("FAIL reset_acc_clear: got %b want 0", o_acc_clear); n_fail++; end
    n_cmp++; if (o_cmp_flag !== 1'b0) begin $display("FAIL reset_cmp_flag: got %b want 0", o_cmp_flag); n_fail++; end
    n_cmp++; if (o_head_idx !== '0) begin $display("FAIL reset_head_idx: got %0d want 0", o_head_idx); n_fail++; end
    n_cmp++; if (o_prune_mask !== '0) begin $display("FAIL reset_mask: got %b want 0", o_prune_mask); n_fail++; end
    n_cmp++; if (o_mask_valid !== 1'b0) begin $display("FAIL reset_mask_valid: got %b want 0", o_mask_valid); n_fail++; end
`ifdef PRUNE_HEAD_STATS_EN
    n_cmp++; if (o_pruned_cnt !== '0) begin $display("FAIL reset_pruned_cnt: got %0d want 0", o_pruned_cnt); n_fail++; end
`endif
    rst_n = 1'b1;
    tile_valid = 1'b0;
    // Idle with tile_valid low must stay idle.
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin $display("FAIL idle_busy: got %b want 0", o_busy); n_fail++; end
  endtask

  task automatic test_single_layer();
    logic [NH-1:0] plan = NH'(10);   // heads 1 and 3 pruned
    run_layer(0, plan, 1'b0, -1);
    n_cmp++; if (obs.timeout !== 1'b0) begin $display("FAIL single_timeout: got %b want 0", obs.timeout); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan) begin $display("FAIL single_mask: got %b want %b", obs.mask_done, plan); n_fail++; end
    n_cmp++; if (obs.n_done !== 1) begin $display("FAIL single_done_cnt: got %0d want 1", obs.n_done); n_fail++; end
    n_cmp++; if (obs.cyc_done !== int'(NH) * HEAD_CYC + 1) begin
      $display("FAIL single_latency: got %0d want %0d", obs.cyc_done, int'(NH) * HEAD_CYC + 1); n_fail++; end
    n_cmp++; if (obs.bad_period !== 0) begin $display("FAIL single_head_period: got %0d bad want 0", obs.bad_period); n_fail++; end
    n_cmp++; if (obs.n_enable !== int'(NH * TPH)) begin $display("FAIL single_enables: got %0d want %0d", obs.n_enable, NH * TPH); n_fail++; end
    n_cmp++; if (obs.n_clear !== int'(NH)) begin $display("FAIL single_clears: got %0d want %0d", obs.n_clear, NH); n_fail++; end
    n_cmp++; if (obs.n_cmp !== int'(NH)) begin $display("FAIL single_cmps: got %0d want %0d", obs.n_cmp, NH); n_fail++; end
    n_cmp++; if (obs.c1_clear !== 1'b1) begin $display("FAIL single_first_clear: got %b want 1", obs.c1_clear); n_fail++; end
    n_cmp++; if (obs.bad_busy !== 0) begin $display("FAIL single_busy: got %0d bad want 0", obs.bad_busy); n_fail++; end
    n_cmp++; if (obs.bad_mv !== 0) begin $display("FAIL single_mv_early: got %0d bad want 0", obs.bad_mv); n_fail++; end
    n_cmp++; if (obs.bad_idx !== 0) begin $display("FAIL single_head_range: got %0d bad want 0", obs.bad_idx); n_fail++; end
    // Cycle after done: mask published, controller idle, strobes quiet.
    @(posedge clk); #2;
    n_cmp++; if (o_mask_valid !== 1'b1) begin $display("FAIL post_mask_valid: got %b want 1", o_mask_valid); n_fail++; end
    n_cmp++; if (o_done !== 1'b0) begin $display("FAIL post_done: got %b want 0", o_done); n_fail++; end
    n_cmp++; if (o_busy !== 1'b0) begin $display("FAIL post_busy: got %b want 0", o_busy); n_fail++; end
    // Mask holds while idle.
    repeat (3) @(posedge clk); #2;
    n_cmp++; if (o_prune_mask !== plan) begin $display("FAIL hold_mask: got %b want %b", o_prune_mask, plan); n_fail++; end
    n_cmp++; if (o_mask_valid !== 1'b1) begin $display("FAIL hold_mask_valid: got %b want 1", o_mask_valid); n_fail++; end
  endtask

  task automatic test_backpressure();
    logic [NH-1:0] plan = NH'($urandom);
    run_layer(1, plan, 1'b0, -1);
    n_cmp++; if (obs.timeout !== 1'b0) begin $display("FAIL bp_timeout: got %b want 0", obs.timeout); n_fail++; end
    n_cmp++; if (obs.n_enable !== int'(NH * TPH)) begin $display("FAIL bp_enables: got %0d want %0d", obs.n_enable, NH * TPH); n_fail++; end
    n_cmp++; if (obs.bad_head !== 0) begin $display("FAIL bp_per_head: got %0d bad heads want 0", obs.bad_head); n_fail++; end
    n_cmp++; if (obs.bad_settle !== 0) begin $display("FAIL bp_settle: got %0d bad want 0", obs.bad_settle); n_fail++; end
    n_cmp++; if (obs.bad_enable !== 0) begin $display("FAIL bp_enable_rule: got %0d bad want 0", obs.bad_enable); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan) begin $display("FAIL bp_mask: got %b want %b", obs.mask_done, plan); n_fail++; end
  endtask

  task automatic test_spurious();
    logic [NH-1:0] plan = NH'($urandom);
    run_layer(0, plan, 1'b1, -1);
    n_cmp++; if (obs.cyc_done !== int'(NH) * HEAD_CYC + 1) begin
      $display("FAIL spur_latency: got %0d want %0d", obs.cyc_done, int'(NH) * HEAD_CYC + 1); n_fail++; end
    n_cmp++; if (obs.n_clear !== int'(NH)) begin $display("FAIL spur_clears: got %0d want %0d", obs.n_clear, NH); n_fail++; end
    n_cmp++; if (obs.n_enable !== int'(NH * TPH)) begin $display("FAIL spur_enables: got %0d want %0d", obs.n_enable, NH * TPH); n_fail++; end
    n_cmp++; if (obs.bad_ready !== 0) begin $display("FAIL spur_ready: got %0d bad want 0", obs.bad_ready); n_fail++; end
    n_cmp++; if (obs.bad_settle !== 0) begin $display("FAIL spur_settle: got %0d bad want 0", obs.bad_settle); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan) begin $display("FAIL spur_mask: got %b want %b", obs.mask_done, plan); n_fail++; end
  endtask

  task automatic test_reset_mid();
    logic [NH-1:0] plan  = NH'($urandom) | NH'(3);
    logic [NH-1:0] plan2 = NH'($urandom);
    int            seen_done = 0;
    run_layer(0, plan, 1'b0, 2);
    n_cmp++; if (obs.reset_hit !== 1'b1) begin $display("FAIL mid_reset_reached: got %b want 1", obs.reset_hit); n_fail++; end
    n_cmp++; if (o_busy !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", o_busy); n_fail++; end
    n_cmp++; if (o_prune_mask !== '0) begin $display("FAIL mid_mask: got %b want 0", o_prune_mask); n_fail++; end
    n_cmp++; if (o_mask_valid !== 1'b0) begin $display("FAIL mid_mask_valid: got %b want 0", o_mask_valid); n_fail++; end
    n_cmp++; if (o_head_idx !== '0) begin $display("FAIL mid_head_idx: got %0d want 0", o_head_idx); n_fail++; end
    n_cmp++; if (o_cmp_flag !== 1'b0) begin $display("FAIL mid_cmp_flag: got %b want 0", o_cmp_flag); n_fail++; end
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_done || o_busy) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin $display("FAIL mid_no_done: got %0d want 0", seen_done); n_fail++; end
    run_layer(2, plan2, 1'b0, -1);
    n_cmp++; if (obs.n_done !== 1) begin $display("FAIL mid_rerun_done: got %0d want 1", obs.n_done); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan2) begin $display("FAIL mid_rerun_mask: got %b want %b", obs.mask_done, plan2); n_fail++; end
    n_cmp++; if (obs.bad_head !== 0) begin $display("FAIL mid_rerun_per_head: got %0d want 0", obs.bad_head); n_fail++; end
  endtask

  task automatic test_back_to_back();
    logic [NH-1:0] plan_a = NH'($urandom) | NH'(1);
    logic [NH-1:0] plan_b = NH'($urandom);
    run_layer(2, plan_a, 1'b0, -1);
    n_cmp++; if (obs.mask_done !== plan_a) begin $display("FAIL b2b_mask_a: got %b want %b", obs.mask_done, plan_a); n_fail++; end
    run_layer(2, plan_b, 1'b0, -1);
    n_cmp++; if (obs.c0_mv !== 1'b1) begin $display("FAIL b2b_prev_valid: got %b want 1", obs.c0_mv); n_fail++; end
    n_cmp++; if (obs.c0_mask !== plan_a) begin $display("FAIL b2b_prev_mask: got %b want %b", obs.c0_mask, plan_a); n_fail++; end
    n_cmp++; if (obs.c1_mv !== 1'b0) begin $display("FAIL b2b_valid_drop: got %b want 0", obs.c1_mv); n_fail++; end
    n_cmp++; if (obs.c1_mask !== '0) begin $display("FAIL b2b_mask_clear: got %b want 0", obs.c1_mask); n_fail++; end
    n_cmp++; if (obs.c1_head !== '0) begin $display("FAIL b2b_head_idx: got %0d want 0", obs.c1_head); n_fail++; end
    n_cmp++; if (obs.c1_clear !== 1'b1) begin $display("FAIL b2b_acc_clear: got %b want 1", obs.c1_clear); n_fail++; end
    n_cmp++; if (obs.c1_busy !== 1'b1) begin $display("FAIL b2b_busy: got %b want 1", obs.c1_busy); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan_b) begin $display("FAIL b2b_mask_b: got %b want %b", obs.mask_done, plan_b); n_fail++; end
    n_cmp++; if (obs.bad_enable !== 0) begin $display("FAIL b2b_enable_rule: got %0d want 0", obs.bad_enable); n_fail++; end
  endtask

  task automatic test_random_layers();
    for (int k = 0; k < 3; k++) begin
      logic [NH-1:0] plan = NH'($urandom);
      run_layer(2, plan, 1'b0, -1);
      n_cmp++; if (obs.mask_done !== plan) begin $display("FAIL rand%0d_mask: got %b want %b", k, obs.mask_done, plan); n_fail++; end
      n_cmp++; if (obs.n_enable !== int'(NH * TPH) || obs.bad_settle !== 0 || obs.bad_mv !== 0) begin
        $display("FAIL rand%0d_flow: enables %0d (want %0d) bad_settle %0d bad_mv %0d",
                 k, obs.n_enable, NH * TPH, obs.bad_settle, obs.bad_mv); n_fail++; end
    end
  endtask

`ifdef PRUNE_HEAD_STATS_EN
  task automatic test_stats();
    logic [NH-1:0] plan = '0;
    while ($countones(plan) < 5) plan[$urandom_range(0, NH - 1)] = 1'b1;
    run_layer(0, plan, 1'b0, -1);
    n_cmp++; if (obs.cnt_done !== 5) begin $display("FAIL stats_cnt: got %0d want 5", obs.cnt_done); n_fail++; end
    n_cmp++; if (obs.mask_done !== plan) begin $display("FAIL stats_mask: got %b want %b", obs.mask_done, plan); n_fail++; end
    run_layer(2, NH'($urandom), 1'b0, -1);
    n_cmp++; if (obs.cnt_c1 !== 0) begin $display("FAIL stats_cleared: got %0d want 0", obs.cnt_c1); n_fail++; end
    n_cmp++; if (obs.cnt_done !== $countones(obs.mask_done)) begin
      $display("FAIL stats_popcount: got %0d want %0d", obs.cnt_done, $countones(obs.mask_done)); n_fail++; end
  endtask
`endif

  initial begin
    test_reset();
    test_single_layer();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random_layers();
`ifdef PRUNE_HEAD_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
